// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score display.
// No ports; holds the converter state enum, digit geometry and 7-segment patterns.
package score_pkg;
    localparam int SCORE_W    = 16;
    localparam int NUM_DIGITS = 5;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} conv_state_e;

    // Patterns are g..a, active-high; entry n is the glyph for digit n.
    localparam logic [9:0][6:0] SEG7_LUT = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [6:0] SEG7_BLANK = 7'h00;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD digit to 7-segment pattern.
// Ports: bcd_i - 4-bit digit; seg_o - segments g..a, active-high (blank for 10..15).
module seg7_decode
    import score_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    assign seg_o = (bcd_i <= 4'd9) ? SEG7_LUT[bcd_i] : SEG7_BLANK;
endmodule

// File: rtl/score_display.sv
// score_display: binary score to 5-digit multiplexed 7-segment display.
// Ports: clk - system clock; rst_n - async active-low reset; score - binary score;
//        seg - segments g..a of the active digit; digit_sel - one-hot digit enable
//        (bit0 = units); busy - binary-to-BCD conversion in progress.
// Define SCORE_DISPLAY_BLANK_EN to blank leading zero digits (units digit always shown).
module score_display
    import score_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SCORE_W-1:0]    score,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  busy
);
    conv_state_e           state_q, state_d;
    logic [SCORE_W-1:0]    score_q, last_q, last_d, work_q, work_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d, disp_q, disp_d, adj;
    logic [3:0]            cnt_q, cnt_d;
    logic [15:0]           scan_q, scan_d;
    logic [2:0]            idx_q, idx_d;
    logic [6:0]            seg_q, seg_d, dec_seg;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  wrap, blank;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        work_d  = work_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        cnt_d   = cnt_q;
        adj     = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        case (state_q)
            IDLE: if (score_q != last_q) begin
                work_d  = score_q;
                last_d  = score_q;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                // Top nibble never reaches 8 for a 16-bit input, so its carry-out is dropped.
                bcd_d   = BCD_W'({adj, work_q[SCORE_W-1]});
                work_d  = work_q << 1;
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == 4'd15) ? LATCH : SHIFT;
            end
            LATCH: begin
                disp_d  = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    seg7_decode u_dec (
        .bcd_i(disp_q[{idx_q, 2'b00} +: 4]),
        .seg_o(dec_seg)
    );

    always_comb begin
        wrap   = (scan_q == 16'(SCAN_DIV - 1));
        scan_d = wrap ? '0 : scan_q + 16'd1;
        idx_d  = wrap ? ((idx_q == 3'(NUM_DIGITS - 1)) ? '0 : idx_q + 3'd1) : idx_q;
`ifdef SCORE_DISPLAY_BLANK_EN
        // Blank when this digit and every more significant one are zero.
        blank  = (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
`else
        blank  = 1'b0;
`endif
        seg_d  = blank ? SEG7_BLANK : dec_seg;
        sel_d  = NUM_DIGITS'(1) << idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            score_q <= '0;
            last_q  <= '0;
            work_q  <= '0;
            bcd_q   <= '0;
            disp_q  <= '0;
            cnt_q   <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= SEG7_LUT[0];
            sel_q   <= NUM_DIGITS'(1);
        end else begin
            state_q <= state_d;
            score_q <= score;
            last_q  <= last_d;
            work_q  <= work_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign seg       = seg_q;
    assign digit_sel = sel_q;
    assign busy      = (state_q != IDLE);
endmodule
